// File: rtl/prominence_topk.sv
// prominence_topk: streaming peak-prominence detector. It tracks rise/fall
// runs of a signed sample frame, computes each peak's prominence above the
// higher of its two neighbouring valleys, keeps the K most prominent peaks
// in a descending list and emits that list as exactly K output beats.
// Optional feature macro: PROM_THRESHOLD_EN adds input min_prom, a per-frame
// threshold that a peak's prominence must strictly exceed to enter the list.
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high; a source never drops valid or changes data/last while valid is
// high and ready is low.
// dbg_state exposes the FSM state (IDLE=0 WAIT=1 RISE=2 FALL=3 FINAL=4 EMIT=5).
module prominence_topk #(
  parameter int DW = 16,
  parameter int IW = 10,
  parameter int K  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] tdata_s,
  input  logic                 tuser_s,
  input  logic                 tlast_s,
  input  logic                 tvalid_s,
  output logic                 tready_s,
  output logic [IW+DW+1:0]     tdata_m,
  output logic                 tlast_m,
  output logic                 tvalid_m,
  input  logic                 tready_m,
  input  logic                 start,
  input  logic                 cont,
  output logic                 busy,
  output logic                 done,
`ifdef PROM_THRESHOLD_EN
  input  logic [DW:0]          min_prom,
`endif
  output logic [2:0]           dbg_state
);

  localparam int PW = DW + 1;
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_BEAT = CW'(K - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RISE  = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, pidx_q, pidx_d, cur_idx;
  logic signed [DW-1:0] prev_q, prev_d, lval_q, lval_d, peak_q, peak_d;
  logic                 fin_fall_q, fin_fall_d, fin_ph_q, fin_ph_d;
  logic                 cand_v_q, cand_v_d;
  logic [IW-1:0]        cand_idx_q, cand_idx_d;
  logic [PW-1:0]        cand_prom_q, cand_prom_d;
  logic [CW-1:0]        emit_cnt_q, emit_cnt_d;
  logic                 done_q, done_d;
  logic                 ent_v_q [K];
  logic                 ent_v_d [K];
  logic [IW-1:0]        ent_idx_q [K];
  logic [IW-1:0]        ent_idx_d [K];
  logic [PW-1:0]        ent_prom_q [K];
  logic [PW-1:0]        ent_prom_d [K];
  logic                 accept, frame_start, clear_list, falling;
  logic                 ins_ok, hit, prev_hit, carry_v;
  logic [IW-1:0]        carry_idx;
  logic [PW-1:0]        carry_prom;
  logic [PW-1:0]        thr;

  // Prominence is hi-lo with hi>=lo; one extra bit holds any DW-bit difference
  function automatic logic [PW-1:0] prom_of(input logic signed [DW-1:0] hi,
                                            input logic signed [DW-1:0] lo);
    return {hi[DW-1], hi} - {lo[DW-1], lo};
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign tready_s    = (state_q == S_WAIT) || (state_q == S_RISE) || (state_q == S_FALL);
  assign accept      = tvalid_s && tready_s;
  assign frame_start = accept && tuser_s;
  assign cur_idx     = (&idx_q) ? idx_q : idx_q + 1'b1;
  assign tvalid_m    = (state_q == S_EMIT);
  assign tlast_m     = (state_q == S_EMIT) && (emit_cnt_q == LAST_BEAT);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state   = state_q;

`ifdef PROM_THRESHOLD_EN
  logic [PW-1:0] thr_q, thr_d;
  assign thr_d = frame_start ? min_prom : thr_q;
  assign thr   = thr_q;
  // Threshold is captured with the frame-start beat and held for the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_q <= '0;
    else       thr_q <= thr_d;
  end
`else
  assign thr = '0;
`endif

  // FSM, rise/fall tracking and candidate generation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pidx_d      = pidx_q;
    prev_d      = prev_q;
    lval_d      = lval_q;
    peak_d      = peak_q;
    fin_fall_d  = fin_fall_q;
    fin_ph_d    = fin_ph_q;
    cand_v_d    = 1'b0;
    cand_idx_d  = cand_idx_q;
    cand_prom_d = cand_prom_q;
    emit_cnt_d  = emit_cnt_q;
    done_d      = 1'b0;
    clear_list  = 1'b0;
    falling     = 1'b0;
    case (state_q)
      S_IDLE: if (start || cont) state_d = S_WAIT;
      S_WAIT: state_d = S_WAIT;
      S_RISE, S_FALL: begin
        if (accept && !tuser_s) begin
          idx_d   = cur_idx;
          prev_d  = tdata_s;
          falling = (state_q == S_FALL);
          if (state_q == S_RISE) begin
            if (tdata_s < prev_q) begin
              peak_d  = prev_q;
              pidx_d  = idx_q;
              falling = 1'b1;
            end
          end else if (tdata_s > prev_q) begin
            cand_v_d    = 1'b1;
            cand_prom_d = prom_of(peak_q, smax(lval_q, prev_q));
            cand_idx_d  = pidx_q;
            lval_d      = prev_q;
            falling     = 1'b0;
          end
          if (tlast_s) begin
            fin_fall_d = falling;
            fin_ph_d   = 1'b0;
            state_d    = S_FINAL;
          end else begin
            state_d = falling ? S_FALL : S_RISE;
          end
        end
      end
      S_FINAL: begin
        // Phase 0 issues the end-of-frame candidate, phase 1 lets it land
        if (!fin_ph_q) begin
          cand_v_d = 1'b1;
          if (fin_fall_q) begin
            cand_prom_d = prom_of(peak_q, smax(lval_q, prev_q));
            cand_idx_d  = pidx_q;
          end else begin
            cand_prom_d = prom_of(prev_q, lval_q);
            cand_idx_d  = idx_q;
          end
          fin_ph_d = 1'b1;
        end else begin
          state_d    = S_EMIT;
          emit_cnt_d = '0;
        end
      end
      S_EMIT: begin
        if (tready_m) begin
          if (emit_cnt_q == LAST_BEAT) begin
            done_d     = 1'b1;
            clear_list = 1'b1;
            state_d    = cont ? S_WAIT : S_IDLE;
          end else begin
            emit_cnt_d = emit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A frame-start beat (first or mid-frame abort) restarts tracking
    if (frame_start) begin
      clear_list = 1'b1;
      cand_v_d   = 1'b0;
      lval_d     = tdata_s;
      prev_d     = tdata_s;
      idx_d      = '0;
      fin_fall_d = 1'b0;
      fin_ph_d   = 1'b0;
      state_d    = tlast_s ? S_FINAL : S_RISE;
    end
  end

  // Sorted insertion: the first slot that is empty or strictly smaller takes
  // the candidate, later slots shift down by one and the tail drops off
  always_comb begin
    ins_ok     = cand_v_q && (cand_prom_q > thr);
    prev_hit   = 1'b0;
    hit        = 1'b0;
    carry_v    = 1'b0;
    carry_idx  = '0;
    carry_prom = '0;
    for (int i = 0; i < K; i++) begin
      ent_v_d[i]    = ent_v_q[i];
      ent_idx_d[i]  = ent_idx_q[i];
      ent_prom_d[i] = ent_prom_q[i];
      hit = ins_ok && (!ent_v_q[i] || (ent_prom_q[i] < cand_prom_q));
      if (hit) begin
        if (!prev_hit) begin
          ent_v_d[i]    = 1'b1;
          ent_idx_d[i]  = cand_idx_q;
          ent_prom_d[i] = cand_prom_q;
        end else begin
          ent_v_d[i]    = carry_v;
          ent_idx_d[i]  = carry_idx;
          ent_prom_d[i] = carry_prom;
        end
      end
      carry_v    = ent_v_q[i];
      carry_idx  = ent_idx_q[i];
      carry_prom = ent_prom_q[i];
      prev_hit   = hit;
      if (clear_list) begin
        ent_v_d[i]    = 1'b0;
        ent_idx_d[i]  = '0;
        ent_prom_d[i] = '0;
      end
    end
  end

  // Output beat selection; empty slots go out as all-zero data
  always_comb begin
    tdata_m = '0;
    for (int i = 0; i < K; i++) begin
      if ((state_q == S_EMIT) && (emit_cnt_q == CW'(i)) && ent_v_q[i])
        tdata_m = {1'b1, ent_idx_q[i], ent_prom_q[i]};
    end
  end

  // Control, frame tracking and candidate registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pidx_q      <= '0;
      prev_q      <= '0;
      lval_q      <= '0;
      peak_q      <= '0;
      fin_fall_q  <= 1'b0;
      fin_ph_q    <= 1'b0;
      cand_v_q    <= 1'b0;
      cand_idx_q  <= '0;
      cand_prom_q <= '0;
      emit_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pidx_q      <= pidx_d;
      prev_q      <= prev_d;
      lval_q      <= lval_d;
      peak_q      <= peak_d;
      fin_fall_q  <= fin_fall_d;
      fin_ph_q    <= fin_ph_d;
      cand_v_q    <= cand_v_d;
      cand_idx_q  <= cand_idx_d;
      cand_prom_q <= cand_prom_d;
      emit_cnt_q  <= emit_cnt_d;
      done_q      <= done_d;
    end
  end

  // Top-K list storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) begin
        ent_v_q[i]    <= 1'b0;
        ent_idx_q[i]  <= '0;
        ent_prom_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        ent_v_q[i]    <= ent_v_d[i];
        ent_idx_q[i]  <= ent_idx_d[i];
        ent_prom_q[i] <= ent_prom_d[i];
      end
    end
  end

endmodule

// File: tb/tb_prominence_topk.sv
// tb_prominence_topk: directed bench for prominence_topk with K=4.
// Build with PROM_THRESHOLD_EN defined to exercise min_prom=4.
module tb_prominence_topk;

  localparam int DW = 16;
  localparam int IW = 10;
  localparam int K  = 4;
  localparam int PW = DW + 1;
  localparam int W  = 1 + IW + DW + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] tdata_s = '0;
  logic                 tuser_s = 1'b0;
  logic                 tlast_s = 1'b0;
  logic                 tvalid_s = 1'b0;
  logic                 tready_s;
  logic [W-1:0]         tdata_m;
  logic                 tlast_m, tvalid_m;
  logic                 tready_m = 1'b0;
  logic                 start = 1'b0;
  logic                 cont = 1'b0;
  logic                 busy, done;
  logic [2:0]           dbg_state;
`ifdef PROM_THRESHOLD_EN
  logic [PW-1:0]        min_prom = PW'(4);
`endif

  logic [W-1:0] exp_q[$];
  logic [3:0]   stall_pat = 4'b1001;
  int checks = 0;
  int errors = 0;

  prominence_topk #(.DW(DW), .IW(IW), .K(K)) dut (
    .clk(clk), .reset(reset),
    .tdata_s(tdata_s), .tuser_s(tuser_s), .tlast_s(tlast_s),
    .tvalid_s(tvalid_s), .tready_s(tready_s),
    .tdata_m(tdata_m), .tlast_m(tlast_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
    .start(start), .cont(cont), .busy(busy), .done(done),
`ifdef PROM_THRESHOLD_EN
    .min_prom(min_prom),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int idx, input int prom);
    return {1'b1, IW'(idx), PW'(prom)};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic send_beat(input int d, input logic u, input logic l);
    int n;
    n = 0;
    tdata_s = DW'(d); tuser_s = u; tlast_s = l; tvalid_s = 1'b1;
    @(negedge clk);
    while (!tready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tready_s) check("sink_ready_timeout", 64'(tready_s), 64'(1));
    @(posedge clk); #1;
    tvalid_s = 1'b0; tuser_s = 1'b0; tlast_s = 1'b0;
  endtask

  // Frame 0,5,1,8,2,3,0: peaks (1,4), (3,6), final (5,1)
  task automatic frame_a();
    exp_q.delete();
`ifdef PROM_THRESHOLD_EN
    exp_q.push_back(mk(3, 6));
    repeat (3) exp_q.push_back('0);
`else
    exp_q.push_back(mk(3, 6));
    exp_q.push_back(mk(1, 4));
    exp_q.push_back(mk(5, 1));
    exp_q.push_back('0);
`endif
    send_beat(0, 1'b1, 1'b0);
    send_beat(5, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b0);
    send_beat(8, 1'b0, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    send_beat(3, 1'b0, 1'b0);
    send_beat(0, 1'b0, 1'b1);
  endtask

  // Frame 1,2,3,4: rising to the end, single candidate (3,3)
  task automatic frame_b();
    exp_q.delete();
`ifdef PROM_THRESHOLD_EN
    repeat (4) exp_q.push_back('0);
`else
    exp_q.push_back(mk(3, 3));
    repeat (3) exp_q.push_back('0);
`endif
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b1);
  endtask

  // Scoreboard: take K beats, optionally stalling with pattern 1-0-0-1
  task automatic collect(input logic stall, input logic [2:0] exp_state);
    int cyc, got, ev;
    logic stalled, rs_seen;
    logic [W-1:0] held, e;
    cyc = 0; got = 0; ev = 0; stalled = 1'b0; rs_seen = 1'b0; held = '0;
    while (got < K && cyc < 300) begin
      @(negedge clk);
      if (tvalid_m) begin
        tready_m = stall ? stall_pat[2'(ev)] : 1'b1;
        ev++;
        if (tready_s) rs_seen = 1'b1;
        if (stalled) check("stall_hold", 64'(tdata_m), 64'(held));
        if (tready_m) begin
          e = exp_q.pop_front();
          check("beat_data", 64'(tdata_m), 64'(e));
          check("beat_last", 64'(tlast_m), 64'(got == K - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = tdata_m;
        end
      end
      cyc++;
    end
    if (got < K) check("emit_timeout", 64'(got), 64'(K));
    check("sink_ready_in_emit", 64'(rs_seen), 64'(0));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(1));
    check("state_after_emit", 64'(dbg_state), 64'(exp_state));
    @(negedge clk);
    check("done_clear", 64'(done), 64'(0));
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    check("rst_tvalid_m", 64'(tvalid_m), 64'(0));
    check("rst_tlast_m", 64'(tlast_m), 64'(0));
    check("rst_tdata_m", 64'(tdata_m), 64'(0));
    check("rst_tready_s", 64'(tready_s), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Basic multi-peak frame
    pulse_start();
    frame_a();
    collect(1'b0, S_IDLE);

    // Stray beat before frame start is dropped; rising frame
    pulse_start();
    send_beat(9, 1'b0, 1'b0);
    frame_b();
    collect(1'b0, S_IDLE);

    // Output backpressure
    pulse_start();
    frame_a();
    collect(1'b1, S_IDLE);

    // Mid-frame abort after one peak
    pulse_start();
    send_beat(0, 1'b1, 1'b0);
    send_beat(5, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b0);
    send_beat(8, 1'b0, 1'b0);
    frame_b();
    collect(1'b0, S_IDLE);

    // Continuous mode with a single-beat frame
    cont = 1'b1;
    @(posedge clk); #1;
    check("cont_enters_wait", 64'(dbg_state), 64'(S_WAIT));
    exp_q.delete();
    repeat (4) exp_q.push_back('0);
    send_beat(7, 1'b1, 1'b1);
    collect(1'b0, S_WAIT);
    cont = 1'b0;

    // Reset while beat 2 is presented
    frame_a();
    n = 0;
    @(negedge clk);
    while (!tvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("emit_reached", 64'(tvalid_m), 64'(1));
    tready_m = 1'b1;
    @(negedge clk);
    tready_m = 1'b0;
    check("beat2_data", 64'(tdata_m), 64'(exp_q[1]));
    #2 reset = 1'b1;
    #1;
    check("async_rst_tvalid_m", 64'(tvalid_m), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_tdata_m", 64'(tdata_m), 64'(0));
    check("async_rst_tready_s", 64'(tready_s), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_state", 64'(dbg_state), 64'(S_IDLE));
    pulse_start();
    frame_a();
    collect(1'b0, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
